// File: rtl/tile_grid_video_gen.sv
// tile_grid_video_gen: two-stage pixel generator for the 2048 board.
// Stage 1 resolves pixel geometry (board/tile hit, column, row) with parallel
// range compares; stage 2 looks up the tile exponent in the frame-latched
// shadow board and drives the palette colour. Everything advances on pix_en.
module tile_grid_video_gen #(
    parameter int GRID_N       = 4,
    parameter int VAL_W        = 4,
    parameter int TILE_PX      = 100,
    parameter int GAP_PX       = 10,
    parameter int ORIGIN_X     = 100,
    parameter int ORIGIN_Y     = 20,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            pix_en,
    input  logic [9:0]                      x,
    input  logic [9:0]                      y,
    input  logic                            active,
    input  logic                            frame_start,
    input  logic [GRID_N*GRID_N*VAL_W-1:0]  board,
    input  logic                            hl_en,
    input  logic [5:0]                      hl_idx,
    output logic [7:0]                      r,
    output logic [7:0]                      g,
    output logic [7:0]                      b,
    output logic                            de_out
);

    localparam int NT    = GRID_N * GRID_N;
    localparam int PITCH = TILE_PX + GAP_PX;
    localparam int SPAN  = GRID_N * TILE_PX + (GRID_N + 1) * GAP_PX;
    localparam int CW    = (GRID_N > 1) ? $clog2(GRID_N) : 1;
    localparam int BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // ---------------- frame-latched state ----------------
    logic [NT*VAL_W-1:0] shadow;
    logic                sh_hl_en;
    logic [5:0]          sh_hl_idx;
    logic [BW-1:0]       blink_cnt;
    logic                blink_ph;

    // Latch board/highlight and step the blink counter once per frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow    <= '0;
            sh_hl_en  <= 1'b0;
            sh_hl_idx <= '0;
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (pix_en && frame_start) begin
            shadow    <= board;
            sh_hl_en  <= hl_en;
            sh_hl_idx <= hl_idx;
            if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // ---------------- stage 1: geometry ----------------
    logic [9:0]        dx, dy;
    logic [31:0]       xw, yw;
    logic              in_board_c, in_tile_c;
    logic [GRID_N-1:0] col_hit, row_hit;
    logic [CW-1:0]     col_c, row_c;

    // Offsets wrap as 10-bit unsigned, so pixels left/above the origin fall out of the board
    assign dx = x - 10'(ORIGIN_X);
    assign dy = y - 10'(ORIGIN_Y);
    assign xw = {22'd0, x};
    assign yw = {22'd0, y};
    assign in_board_c = ({22'd0, dx} < 32'(SPAN)) && ({22'd0, dy} < 32'(SPAN));

    for (genvar c = 0; c < GRID_N; c++) begin : g_axis
        localparam int LO_X = ORIGIN_X + GAP_PX + c * PITCH;
        localparam int LO_Y = ORIGIN_Y + GAP_PX + c * PITCH;
        assign col_hit[c] = (xw >= 32'(LO_X)) && (xw < 32'(LO_X + TILE_PX));
        assign row_hit[c] = (yw >= 32'(LO_Y)) && (yw < 32'(LO_Y + TILE_PX));
    end

    assign in_tile_c = (|col_hit) && (|row_hit);

    // One-hot hit vectors to binary column/row
    always_comb begin
        col_c = '0;
        row_c = '0;
        for (int i = 0; i < GRID_N; i++) begin
            if (col_hit[i]) col_c = CW'(i);
            if (row_hit[i]) row_c = CW'(i);
        end
    end

    logic          s1_in_board, s1_in_tile, s1_active;
    logic [CW-1:0] s1_col, s1_row;

    // Stage-1 pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_in_board <= 1'b0;
            s1_in_tile  <= 1'b0;
            s1_col      <= '0;
            s1_row      <= '0;
            s1_active   <= 1'b0;
        end else if (pix_en) begin
            s1_in_board <= in_board_c;
            s1_in_tile  <= in_tile_c;
            s1_col      <= col_c;
            s1_row      <= row_c;
            s1_active   <= active;
        end
    end

    // ---------------- stage 2: colour ----------------
    function automatic logic [23:0] palette(input logic [VAL_W-1:0] v);
        case (int'(v))
            0:       return 24'hCDC1B4;
            1:       return 24'hEEE4DA;
            2:       return 24'hEDE0C8;
            3:       return 24'hF2B179;
            4:       return 24'hF59563;
            5:       return 24'hF67C5F;
            6:       return 24'hF65E3B;
            7:       return 24'hEDCF72;
            8:       return 24'hEDCC61;
            9:       return 24'hEDC850;
            10:      return 24'hEDC53F;
            11:      return 24'hEDC22E;
            default: return 24'h3C3A32;
        endcase
    endfunction

    logic [5:0]       tidx;
    logic [VAL_W-1:0] tile_v;
    logic             hl_hit;
    logic [23:0]      rgb_c;

    // tidx is always < NT, so an out-of-range highlight index can never match
    assign tidx   = 6'(s1_row) * 6'(GRID_N) + 6'(s1_col);
    assign hl_hit = sh_hl_en && (sh_hl_idx == tidx) && blink_ph;

    // Tile exponent mux from the shadow board
    always_comb begin
        tile_v = '0;
        for (int i = 0; i < NT; i++) begin
            if (tidx == 6'(i)) tile_v = shadow[i*VAL_W +: VAL_W];
        end
    end

    // Colour priority: blanking, outside board, gap, highlight, palette
    always_comb begin
        rgb_c = 24'h000000;
        if (s1_active && s1_in_board) begin
            if (!s1_in_tile)  rgb_c = 24'hBBADA0;
            else if (hl_hit)  rgb_c = 24'hFFFFFF;
            else              rgb_c = palette(tile_v);
        end
    end

    // Stage-2 output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r      <= '0;
            g      <= '0;
            b      <= '0;
            de_out <= 1'b0;
        end else if (pix_en) begin
            r      <= rgb_c[23:16];
            g      <= rgb_c[15:8];
            b      <= rgb_c[7:0];
            de_out <= s1_active;
        end
    end

endmodule
